vga_sync_monitor: RTL and testbench
===================================

VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96, HS pulse width in pixels.
REQ-004 Parameter H_BP, 48, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 Parameter V_FP, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, VS pulse width in lines.
REQ-008 Parameter V_BP, 33, vertical back porch in lines.
REQ-009 Parameter SYNC_POL, 0, asserted sync level: 0 = active-low.
REQ-010 Clocking: one clock, clk; reset rst is asynchronous and active-high.
REQ-011 Port clk, in, 1: 100 MHz system clock.
REQ-012 Port rst, in, 1: asynchronous active-high reset.
REQ-013 Port pix_ce, in, 1: pixel-rate enable (25 MHz); all state advances only when pix_ce=1.
REQ-014 Port HS, in, 1: horizontal sync under test.
REQ-015 Port VS, in, 1: vertical sync under test.
REQ-016 Ports R (3), G (3), B (2), in: pixel colour under test.
REQ-017 Port err_clr, in, 1: clears the sticky error flags.
REQ-018 Port hpos, out, 11: active-area column, 0..H_ACTIVE-1.
REQ-019 Port vpos, out, 11: active-area row, 0..V_ACTIVE-1.
REQ-020 Port de, out, 1: current pixel is active and the monitor is locked.
REQ-021 Port locked, out, 1: timing verified.
REQ-022 Port err, out, 4: sticky flags, bit 0 HS width, bit 1 line length, bit 2 VS width, bit 3 frame length.
REQ-023 Port frame_count, out, 16: locked frames seen; wraps 65535 to 0.
REQ-024 Port lit_count, out, 19: count of non-black active pixels in the last completed frame.

Function
REQ-025 All registers shall update only on clk edges where pix_ce=1; outputs are registered with 1 pix_ce of latency from the sampled inputs.
REQ-026 HS and VS shall be registered each pix_ce; assertion = previous deasserted and current asserted, deassertion = the reverse, per SYNC_POL.
REQ-027 hcnt (11 bit) shall be set to 0 on HS assertion, otherwise increment, saturating at 2047.
REQ-028 On HS assertion, line length = hcnt+1; if not equal to H_ACTIVE+H_FP+H_SYNC+H_BP (800), set err[1]; check suppressed in SEARCH.
REQ-029 On HS deassertion, HS-asserted sample count not equal to H_SYNC sets err[0].
REQ-030 vcnt (11 bit) shall increment on each HS assertion and be set to 0 on an HS assertion at which VS assertion is detected; VS is sampled only at HS assertions.
REQ-031 At VS assertion, vcnt+1 not equal to 525 (V total) sets err[3]; at the VS deassertion line, VS-asserted line count not equal to V_SYNC sets err[2].
REQ-032 State machine has three states:
- SEARCH: waits for the first VS assertion, then goes to MEASURE.
- MEASURE: at the next VS assertion, goes to LOCKED if no error was detected during the frame, otherwise stays in MEASURE.
- LOCKED: any new error returns to MEASURE on the same pix_ce.
REQ-033 locked = 1 exactly in LOCKED.
REQ-034 frame_count shall increment at each VS assertion that occurs in LOCKED or that causes entry to LOCKED.
REQ-035 Active window: hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) = 144..783 and vcnt in [V_SYNC+V_BP, +V_ACTIVE) = 35..514.
REQ-036 In the active window: hpos = hcnt-144, vpos = vcnt-35, de = locked. Outside it, hpos = vpos = 0 and de = 0.
REQ-037 The lit accumulator shall count in-window pixels with {R,G,B} not equal to 0, latch into lit_count at VS assertion, then clear; this holds in every state except SEARCH.
REQ-038 err bits are sticky; err_clr clears all bits; an error detected in the same pix_ce as err_clr shall leave its bit set.
REQ-039 A saturated hcnt (sync lost) shall set err[1] and force MEASURE.

Reset
REQ-040 rst=1 shall immediately force SEARCH and zero all counters and outputs: hpos, vpos, de, locked, err, frame_count, lit_count.
REQ-041 rst asserted mid-frame shall discard partial measurements; after release, the monitor resynchronises from the next VS assertion.

Verification
REQ-042 Nominal 640x480@60 timing for 3 frames -> locked=1 at the 2nd VS assertion, err=0, frame_count=2 after the 3rd VS assertion.
REQ-043 One line with HS width 95 while locked -> err[0]=1 and locked=0 at the deassertion pix_ce; relock after one clean frame; err[0] remains 1 until err_clr.
REQ-044 Locked; 51x76 non-black box at hpos 100, vpos 50, rest black -> lit_count=3876 after the next VS assertion.
REQ-045 Locked; hcnt=144 on line vcnt=35 -> de=1, hpos=0, vpos=0; hcnt=784 -> de=0.
REQ-046 err_clr pulsed in the same pix_ce as a line-length error -> err[1]=1; err_clr alone -> err=0.
REQ-047 rst mid-frame while locked -> all outputs 0 in the same cycle; pix_ce held 0 for 1000 clk -> no output change.

Source files
------------

// File: rtl/vga_sync_monitor.sv
// Passive VGA timing monitor: measures HS/VS against the expected raster and reports lock, errors,
// active-area position and the number of non-black pixels per frame. State advances only on pix_ce.
module vga_sync_monitor #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_ce,
   input  logic        HS,
   input  logic        VS,
   input  logic [2:0]  R,
   input  logic [2:0]  G,
   input  logic [1:0]  B,
   input  logic        err_clr,
   output logic [10:0] hpos,
   output logic [10:0] vpos,
   output logic        de,
   output logic        locked,
   output logic [3:0]  err,
   output logic [15:0] frame_count,
   output logic [18:0] lit_count
);

   localparam logic [10:0] H_TOTAL_L = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
   localparam logic [10:0] V_TOTAL_L = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
   localparam logic [10:0] H_SYNC_L  = 11'(H_SYNC);
   localparam logic [10:0] V_SYNC_L  = 11'(V_SYNC);
   localparam logic [10:0] H_WIN_LO  = 11'(H_SYNC + H_BP);
   localparam logic [10:0] H_WIN_HI  = 11'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [10:0] V_WIN_LO  = 11'(V_SYNC + V_BP);
   localparam logic [10:0] V_WIN_HI  = 11'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [10:0] CNT_MAX   = 11'h7FF;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        hs_q, vs_line_q;
   logic [10:0] hcnt_q, hcnt_d;
   logic [10:0] vcnt_q, vcnt_d;
   logic [10:0] hsw_q, hsw_d;
   logic [10:0] vsw_q, vsw_d;
   logic        frame_err_q, frame_err_d;
   logic [3:0]  err_q, err_d, err_new;
   logic [15:0] fcnt_q, fcnt_d;
   logic [18:0] lit_acc_q, lit_acc_d;
   logic [18:0] lit_q, lit_d;
   logic [10:0] hpos_q, hpos_d;
   logic [10:0] vpos_q, vpos_d;
   logic        de_q, de_d;

   logic hs_now, vs_now, hs_rise, hs_fall, vs_rise, vs_fall;
   logic checking, in_win, lit_px;

   // Sync levels are normalised to "asserted"; VS edges are only recognised at HS assertions.
   assign hs_now   = (HS == SYNC_POL);
   assign vs_now   = (VS == SYNC_POL);
   assign hs_rise  = hs_now & ~hs_q;
   assign hs_fall  = ~hs_now & hs_q;
   assign vs_rise  = hs_rise & vs_now & ~vs_line_q;
   assign vs_fall  = hs_rise & ~vs_now & vs_line_q;
   assign checking = (state_q != SEARCH);

   always_comb begin
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      hsw_d  = hsw_q;
      vsw_d  = vsw_q;
      if (hs_rise) begin
         hcnt_d = '0;
      end else if (hcnt_q != CNT_MAX) begin
         hcnt_d = hcnt_q + 11'd1;
      end
      if (hs_rise) begin
         hsw_d = 11'd1;
      end else if (hs_now && (hsw_q != CNT_MAX)) begin
         hsw_d = hsw_q + 11'd1;
      end
      if (vs_rise) begin
         vcnt_d = '0;
         vsw_d  = 11'd1;
      end else if (hs_rise) begin
         if (vcnt_q != CNT_MAX) begin
            vcnt_d = vcnt_q + 11'd1;
         end
         if (vs_now && (vsw_q != CNT_MAX)) begin
            vsw_d = vsw_q + 11'd1;
         end
      end
   end

   // Until the first VS assertion the counters hold partial data, so nothing is checked in SEARCH.
   always_comb begin
      err_new = '0;
      if (checking) begin
         if (hs_fall && (hsw_q != H_SYNC_L)) begin
            err_new[0] = 1'b1;
         end
         if (hs_rise && ((hcnt_q + 11'd1) != H_TOTAL_L)) begin
            err_new[1] = 1'b1;
         end
         if (!hs_rise && (hcnt_q == CNT_MAX)) begin
            err_new[1] = 1'b1;
         end
         if (vs_fall && (vsw_q != V_SYNC_L)) begin
            err_new[2] = 1'b1;
         end
         if (vs_rise && ((vcnt_q + 11'd1) != V_TOTAL_L)) begin
            err_new[3] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      frame_err_d = frame_err_q | (|err_new);
      fcnt_d      = fcnt_q;
      case (state_q)
         SEARCH: begin
            frame_err_d = 1'b0;
            if (vs_rise) begin
               state_d = MEASURE;
            end
         end
         MEASURE: begin
            if (vs_rise) begin
               frame_err_d = 1'b0;
               if (!frame_err_q && (err_new == 4'd0)) begin
                  state_d = LOCKED;
                  fcnt_d  = fcnt_q + 16'd1;
               end
            end
         end
         LOCKED: begin
            if (vs_rise) begin
               fcnt_d      = fcnt_q + 16'd1;
               frame_err_d = 1'b0;
            end
            if (err_new != 4'd0) begin
               state_d = MEASURE;
            end
         end
         default: begin
            state_d = SEARCH;
         end
      endcase
   end

   // Window and position use the next-state counters so the registered outputs line up with hcnt/vcnt.
   assign in_win = (hcnt_d >= H_WIN_LO) && (hcnt_d < H_WIN_HI) &&
                   (vcnt_d >= V_WIN_LO) && (vcnt_d < V_WIN_HI);
   assign lit_px = in_win && ({R, G, B} != 8'd0);

   always_comb begin
      lit_acc_d = lit_acc_q;
      lit_d     = lit_q;
      hpos_d    = '0;
      vpos_d    = '0;
      de_d      = 1'b0;
      if (checking) begin
         if (vs_rise) begin
            lit_d     = lit_acc_q;
            lit_acc_d = '0;
         end else if (lit_px) begin
            lit_acc_d = lit_acc_q + 19'd1;
         end
      end
      if (in_win) begin
         hpos_d = hcnt_d - H_WIN_LO;
         vpos_d = vcnt_d - V_WIN_LO;
         de_d   = (state_d == LOCKED);
      end
      err_d = (err_clr ? 4'd0 : err_q) | err_new;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= SEARCH;
         hs_q        <= 1'b0;
         vs_line_q   <= 1'b0;
         hcnt_q      <= '0;
         vcnt_q      <= '0;
         hsw_q       <= '0;
         vsw_q       <= '0;
         frame_err_q <= 1'b0;
         err_q       <= '0;
         fcnt_q      <= '0;
         lit_acc_q   <= '0;
         lit_q       <= '0;
         hpos_q      <= '0;
         vpos_q      <= '0;
         de_q        <= 1'b0;
      end else if (pix_ce) begin
         state_q     <= state_d;
         hs_q        <= hs_now;
         if (hs_rise) begin
            vs_line_q <= vs_now;
         end
         hcnt_q      <= hcnt_d;
         vcnt_q      <= vcnt_d;
         hsw_q       <= hsw_d;
         vsw_q       <= vsw_d;
         frame_err_q <= frame_err_d;
         err_q       <= err_d;
         fcnt_q      <= fcnt_d;
         lit_acc_q   <= lit_acc_d;
         lit_q       <= lit_d;
         hpos_q      <= hpos_d;
         vpos_q      <= vpos_d;
         de_q        <= de_d;
      end
   end

   assign hpos        = hpos_q;
   assign vpos        = vpos_q;
   assign de          = de_q;
   assign locked      = (state_q == LOCKED);
   assign err         = err_q;
   assign frame_count = fcnt_q;
   assign lit_count   = lit_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a reduced raster (25x19) so whole frames stay short;
// expected values are queued as stimulus is driven and checked after the pix_ce edge that produces them.
module tb_vga_sync_monitor;

   localparam int HA  = 16;
   localparam int HF  = 2;
   localparam int HSY = 4;
   localparam int HB  = 3;
   localparam int VA  = 12;
   localparam int VF  = 2;
   localparam int VSY = 2;
   localparam int VB  = 3;
   localparam int HT  = HA + HF + HSY + HB;
   localparam int VT  = VA + VF + VSY + VB;
   localparam int HLO = HSY + HB;
   localparam int VLO = VSY + VB;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pix_ce = 1'b0;
   logic        HS = 1'b1;
   logic        VS = 1'b1;
   logic [2:0]  R = '0;
   logic [2:0]  G = '0;
   logic [1:0]  B = '0;
   logic        err_clr = 1'b0;
   logic [10:0] hpos;
   logic [10:0] vpos;
   logic        de;
   logic        locked;
   logic [3:0]  err;
   logic [15:0] frame_count;
   logic [18:0] lit_count;

   vga_sync_monitor #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
      .SYNC_POL(1'b0)
   ) dut (
      .clk(clk), .rst(rst), .pix_ce(pix_ce), .HS(HS), .VS(VS),
      .R(R), .G(G), .B(B), .err_clr(err_clr),
      .hpos(hpos), .vpos(vpos), .de(de), .locked(locked), .err(err),
      .frame_count(frame_count), .lit_count(lit_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   box_mode = 0;
   bit   pos_chk = 1'b0;
   bit   exp_lock = 1'b0;
   bit   clr_v = 1'b0;

   function automatic logic [31:0] observe(input int sel);
      logic [31:0] v;
      case (sel)
         0: v = 32'(hpos);
         1: v = 32'(vpos);
         2: v = 32'(de);
         3: v = 32'(locked);
         4: v = 32'(err);
         5: v = 32'(frame_count);
         6: v = 32'(lit_count);
         default: v = 32'hFFFF_FFFF;
      endcase
      return v;
   endfunction

   task automatic push(input string tag, input int sel, input int val);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.val = 32'(val);
      sb.push_back(e);
   endtask

   task automatic push_status(input string tag, input int lk, input int fc, input int er);
      push({tag, ".locked"}, 3, lk);
      push({tag, ".frame_count"}, 5, fc);
      push({tag, ".err"}, 4, er);
   endtask

   task automatic push_all(input string tag, input int hp, input int vp, input int d,
                           input int lk, input int er, input int fc, input int lit);
      push({tag, ".hpos"}, 0, hp);
      push({tag, ".vpos"}, 1, vp);
      push({tag, ".de"}, 2, d);
      push_status(tag, lk, fc, er);
      push({tag, ".lit_count"}, 6, lit);
   endtask

   task automatic drain();
      exp_t        e;
      logic [31:0] o;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = observe(e.sel);
         checks++;
         assert (o === e.val) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", e.tag, o, e.val);
         end
      end
   endtask

   function automatic bit in_window(input int l, input int p);
      return (p >= HLO) && (p < HLO + HA) && (l >= VLO) && (l < VLO + VA);
   endfunction

   function automatic logic [7:0] colour(input int l, input int p);
      logic [7:0] c;
      c = 8'h00;
      case (box_mode)
         1: if (in_window(l, p) && (p - HLO >= 3) && (p - HLO < 8) &&
                (l - VLO >= 2) && (l - VLO < 6)) c = 8'h01;
         2: c = 8'h80;
         default: c = 8'h00;
      endcase
      return c;
   endfunction

   // One pixel: inputs applied just after an edge, sampled on the next, then checked 1 ns later.
   task automatic pix(input bit hs_a, input bit vs_a, input logic [7:0] rgb);
      HS        = ~hs_a;
      VS        = ~vs_a;
      {R, G, B} = rgb;
      err_clr   = clr_v;
      pix_ce    = 1'b1;
      @(posedge clk);
      #1;
      pix_ce  = 1'b0;
      err_clr = 1'b0;
      drain();
      @(posedge clk);
      #1;
   endtask

   task automatic run_pixels(input int l, input int p0, input int p1, input int hsw);
      bit w;
      for (int p = p0; p < p1; p++) begin
         if (pos_chk && (l == VLO - 1 || l == VLO || l == VLO + VA - 1 || l == VLO + VA)) begin
            w = in_window(l, p);
            push($sformatf("hpos l%0d p%0d", l, p), 0, w ? p - HLO : 0);
            push($sformatf("vpos l%0d p%0d", l, p), 1, w ? l - VLO : 0);
            push($sformatf("de l%0d p%0d", l, p), 2, (w && exp_lock) ? 1 : 0);
         end
         pix(p < hsw, l < VSY, colour(l, p));
      end
   endtask

   task automatic run_lines(input int l0, input int l1);
      for (int l = l0; l < l1; l++) begin
         run_pixels(l, 0, HT, HSY);
      end
   endtask

   initial begin
      rst = 1'b1;
      @(posedge clk);
      #1;
      push_all("reset", 0, 0, 0, 0, 0, 0, 0);
      drain();
      rst = 1'b0;
      @(posedge clk);
      #1;

      // first VS assertion only leaves SEARCH; the second locks
      push_status("vs1", 0, 0, 0);
      run_lines(0, VT);
      pos_chk  = 1'b1;
      exp_lock = 1'b1;
      push_status("vs2", 1, 1, 0);
      run_lines(0, VT);
      pos_chk  = 1'b0;
      box_mode = 1;
      push_status("vs3", 1, 2, 0);
      push("vs3.lit_count", 6, 0);
      run_lines(0, VT);
      box_mode = 2;
      push_status("vs4", 1, 3, 0);
      push("box.lit_count", 6, 20);
      run_lines(0, VT);
      box_mode = 0;
      push_status("vs5", 1, 4, 0);
      push("full.lit_count", 6, HA * VA);

      // one short HS pulse on line 3 while locked
      run_lines(0, 3);
      run_pixels(3, 0, HSY - 2, HSY - 1);
      push_status("pre_hs_short", 1, 4, 0);
      run_pixels(3, HSY - 2, HSY - 1, HSY - 1);
      push_status("hs_short", 0, 4, 1);
      run_pixels(3, HSY - 1, HT, HSY - 1);
      run_lines(4, VT);
      push_status("vs6", 0, 4, 1);
      push("vs6.lit_count", 6, 0);
      run_lines(0, VT);
      push_status("vs7_relock", 1, 5, 1);

      // short line 6, err_clr at the next HS assertion, then err_clr alone on line 9
      run_lines(0, 6);
      run_pixels(6, 0, HT - 1, HSY);
      clr_v = 1'b1;
      push_status("clr_with_len_err", 0, 5, 2);
      run_pixels(7, 0, 1, HSY);
      clr_v = 1'b0;
      run_pixels(7, 1, HT, HSY);
      run_lines(8, 9);
      run_pixels(9, 0, 5, HSY);
      clr_v = 1'b1;
      push("clr_alone.err", 4, 0);
      run_pixels(9, 5, 6, HSY);
      clr_v = 1'b0;
      run_pixels(9, 6, HT, HSY);
      run_lines(10, VT);
      push_status("vs8", 0, 5, 0);
      run_lines(0, VT);
      push_status("vs9", 1, 6, 0);

      // HS disappears on line 10 until hcnt saturates
      run_lines(0, 10);
      run_pixels(10, 0, 2047, HSY);
      push_status("pre_sat", 1, 6, 0);
      run_pixels(10, 2047, 2048, HSY);
      push_status("sat", 0, 6, 2);
      run_pixels(10, 2048, 2049, HSY);
      run_lines(11, VT);
      push_status("vs10", 0, 6, 2);
      run_lines(0, VT);
      push_status("vs11", 1, 7, 2);

      // stop mid-frame inside the active area, then hold pix_ce low with noisy inputs
      run_lines(0, 8);
      run_pixels(8, 0, 11, HSY);
      repeat (1000) begin
         HS        = 1'($urandom);
         VS        = 1'($urandom);
         {R, G, B} = 8'($urandom);
         err_clr   = 1'($urandom);
         @(posedge clk);
         #1;
      end
      err_clr = 1'b0;
      push_all("idle", 3, 3, 1, 1, 2, 7, 0);
      drain();

      // asynchronous reset between clock edges
      #2;
      rst = 1'b1;
      #1;
      push_all("rst_mid", 0, 0, 0, 0, 0, 0, 0);
      drain();
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_pixels(8, 11, HT, HSY);
      run_lines(9, VT);
      push_status("resync_vs", 0, 0, 0);
      run_lines(0, VT);
      push_status("relock_after_rst", 1, 1, 0);
      run_lines(0, VT);
      push_status("fc_after_rst", 1, 2, 0);
      push("after_rst.lit_count", 6, 0);
      run_lines(0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
